// File: rtl/lobinho_pkg.sv
// lobinho_pkg: shared game constants and phase encoding
package lobinho_pkg;
    localparam int N_JOGADORES = 5;
    localparam int ID_W = 3;
    localparam logic [ID_W-1:0] ID_PULA = 3'd7;
    typedef enum logic [1:0] {
        ESPERA  = 2'b00,
        NOITE   = 2'b01,
        RESOLVE = 2'b10,
        DIA     = 2'b11
    } fase_t;
endpackage

// File: rtl/id_legal.sv
// id_legal: a player id is legal when it names a real player who is still alive
module id_legal #(
    parameter int N = 5,
    parameter int W = 3
) (
    input  logic [W-1:0] id,
    input  logic [N-1:0] mortes,
    output logic         legal
);
    // Pad the dead vector to the full id range so every id value indexes safely
    logic [2**W-1:0] mortes_ext;
    assign mortes_ext = {{(2**W-N){1'b0}}, mortes};
    assign legal = (int'(id) < N) && !mortes_ext[id];
endmodule

// File: rtl/registro_mortes.sv
// registro_mortes: round sequencer that keeps the sticky dead-player vector
module registro_mortes
    import lobinho_pkg::*;
(
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   reinicia,
    input  logic                   inicio_noite,
    input  logic                   alvo_valid,
    input  logic [ID_W-1:0]        alvo_id,
    input  logic                   protege_valid,
    input  logic [ID_W-1:0]        protege_id,
    input  logic                   fim_noite,
    input  logic                   voto_valid,
    input  logic [ID_W-1:0]        voto_id,
    output logic [N_JOGADORES-1:0] mortes,
    output logic                   morte_valid,
    output logic [ID_W-1:0]        morte_id,
    output logic                   erro,
    output logic [1:0]             fase
);
    fase_t                  fase_q, fase_d;
    logic [N_JOGADORES-1:0] mortes_q, mortes_d;
    logic                   morte_valid_q, morte_valid_d;
    logic [ID_W-1:0]        morte_id_q, morte_id_d;
    logic                   erro_q, erro_d;
    logic [ID_W-1:0]        alvo_q, alvo_d, prot_q, prot_d;
    logic                   alvo_set_q, alvo_set_d, prot_set_q, prot_set_d;
    logic                   alvo_ok, prot_ok, voto_ok;

    id_legal #(.N(N_JOGADORES), .W(ID_W)) u_alvo (.id(alvo_id), .mortes(mortes_q), .legal(alvo_ok));
    id_legal #(.N(N_JOGADORES), .W(ID_W)) u_prot (.id(protege_id), .mortes(mortes_q), .legal(prot_ok));
    id_legal #(.N(N_JOGADORES), .W(ID_W)) u_voto (.id(voto_id), .mortes(mortes_q), .legal(voto_ok));

    // Next-state: phase sequencing, night latches, kills and error pulses
    always_comb begin
        fase_d        = fase_q;
        mortes_d      = mortes_q;
        morte_valid_d = 1'b0;
        morte_id_d    = morte_id_q;
        erro_d        = 1'b0;
        alvo_d        = alvo_q;
        alvo_set_d    = alvo_set_q;
        prot_d        = prot_q;
        prot_set_d    = prot_set_q;
        if (reinicia) begin
            fase_d     = ESPERA;
            mortes_d   = '0;
            morte_id_d = '0;
            alvo_set_d = 1'b0;
            prot_set_d = 1'b0;
        end else begin
            case (fase_q)
                ESPERA: if (inicio_noite) begin
                    fase_d     = NOITE;
                    alvo_set_d = 1'b0;
                    prot_set_d = 1'b0;
                end
                NOITE: begin
                    if (alvo_valid) begin
                        if (alvo_ok) begin
                            alvo_d     = alvo_id;
                            alvo_set_d = 1'b1;
                        end else erro_d = 1'b1;
                    end
                    if (protege_valid) begin
                        if (prot_ok) begin
                            prot_d     = protege_id;
                            prot_set_d = 1'b1;
                        end else erro_d = 1'b1;
                    end
                    if (fim_noite) fase_d = RESOLVE;
                end
                RESOLVE: begin
                    fase_d = DIA;
                    if (alvo_set_q && !(prot_set_q && prot_q == alvo_q)) begin
                        mortes_d[alvo_q] = 1'b1;
                        morte_valid_d    = 1'b1;
                        morte_id_d       = alvo_q;
                    end
                end
                DIA: if (voto_valid) begin
                    if (voto_ok) begin
                        mortes_d[voto_id] = 1'b1;
                        morte_valid_d     = 1'b1;
                        morte_id_d        = voto_id;
                        fase_d            = ESPERA;
                    end else if (voto_id == ID_PULA) fase_d = ESPERA;
                    else erro_d = 1'b1;
                end
                default: fase_d = ESPERA;
            endcase
        end
    end

    // State and output registers with asynchronous clear
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fase_q        <= ESPERA;
            mortes_q      <= '0;
            morte_valid_q <= 1'b0;
            morte_id_q    <= '0;
            erro_q        <= 1'b0;
            alvo_q        <= '0;
            alvo_set_q    <= 1'b0;
            prot_q        <= '0;
            prot_set_q    <= 1'b0;
        end else begin
            fase_q        <= fase_d;
            mortes_q      <= mortes_d;
            morte_valid_q <= morte_valid_d;
            morte_id_q    <= morte_id_d;
            erro_q        <= erro_d;
            alvo_q        <= alvo_d;
            alvo_set_q    <= alvo_set_d;
            prot_q        <= prot_d;
            prot_set_q    <= prot_set_d;
        end
    end

    assign fase        = fase_q;
    assign mortes      = mortes_q;
    assign morte_valid = morte_valid_q;
    assign morte_id    = morte_id_q;
    assign erro        = erro_q;
endmodule

// File: tb/tb_registro_mortes.sv
// tb_registro_mortes: directed rounds checked against a per-cycle game model
module tb_registro_mortes;
    logic       clock = 1'b0;
    logic       reset_n, reinicia, inicio_noite, alvo_valid, protege_valid, fim_noite, voto_valid;
    logic [2:0] alvo_id, protege_id, voto_id;
    logic [4:0] mortes;
    logic       morte_valid, erro;
    logic [2:0] morte_id;
    logic [1:0] fase;
    int total = 0;
    int bad = 0;

    int m_fase, m_alvo, m_prot, m_id;
    bit m_dead [5];
    bit m_mv, m_err;

    registro_mortes dut (
        .clock(clock), .reset_n(reset_n), .reinicia(reinicia), .inicio_noite(inicio_noite),
        .alvo_valid(alvo_valid), .alvo_id(alvo_id), .protege_valid(protege_valid),
        .protege_id(protege_id), .fim_noite(fim_noite), .voto_valid(voto_valid),
        .voto_id(voto_id), .mortes(mortes), .morte_valid(morte_valid), .morte_id(morte_id),
        .erro(erro), .fase(fase)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int dead_vec();
        int v = 0;
        for (int i = 0; i < 5; i++) if (m_dead[i]) v += (1 << i);
        return v;
    endfunction

    function automatic bit legal(input int id);
        return id < 5 && !m_dead[id];
    endfunction

    task automatic model_reset();
        m_fase = 0; m_alvo = -1; m_prot = -1; m_id = 0; m_mv = 0; m_err = 0;
        for (int i = 0; i < 5; i++) m_dead[i] = 0;
    endtask

    task automatic kill(input int id);
        m_dead[id] = 1; m_mv = 1; m_id = id;
    endtask

    // Game rules: unset target/protection are -1, so "protected" is simply prot == alvo
    task automatic model_update();
        m_mv = 0; m_err = 0;
        if (reinicia) model_reset();
        else if (m_fase == 0) begin
            if (inicio_noite) begin m_fase = 1; m_alvo = -1; m_prot = -1; end
        end else if (m_fase == 1) begin
            if (alvo_valid) begin if (legal(int'(alvo_id))) m_alvo = int'(alvo_id); else m_err = 1; end
            if (protege_valid) begin if (legal(int'(protege_id))) m_prot = int'(protege_id); else m_err = 1; end
            if (fim_noite) m_fase = 2;
        end else if (m_fase == 2) begin
            if (m_alvo >= 0 && m_alvo != m_prot) kill(m_alvo);
            m_fase = 3;
        end else if (voto_valid) begin
            if (legal(int'(voto_id))) begin kill(int'(voto_id)); m_fase = 0; end
            else if (voto_id == 3'd7) m_fase = 0;
            else m_err = 1;
        end
    endtask

    always @(negedge clock) begin
        chk("fase", int'(fase), m_fase);
        chk("mortes", int'(mortes), dead_vec());
        chk("morte_valid", int'(morte_valid), int'(m_mv));
        chk("morte_id", int'(morte_id), m_id);
        chk("erro", int'(erro), int'(m_err));
    end

    task automatic tick();
        @(posedge clock);
        model_update();
        #1;
        {reinicia, inicio_noite, alvo_valid, protege_valid, fim_noite, voto_valid} = '0;
    endtask

    initial begin
        reset_n = 1'b0;
        {reinicia, inicio_noite, alvo_valid, protege_valid, fim_noite, voto_valid} = '0;
        alvo_id = 0; protege_id = 0; voto_id = 0;
        model_reset();
        repeat (2) @(posedge clock);
        #2 reset_n = 1'b1;
        chk("reset fase", int'(fase), 0);
        chk("reset mortes", int'(mortes), 0);
        // reset mid-night with a target latched
        inicio_noite = 1; tick();
        alvo_valid = 1; alvo_id = 2; tick();
        #2 reset_n = 1'b0; model_reset();
        #4 reset_n = 1'b1;
        fim_noite = 1; tick();
        tick();
        chk("midreset fase", int'(fase), 0);
        chk("midreset mortes", int'(mortes), 0);
        chk("midreset mv", int'(morte_valid), 0);
        // strobes in ESPERA are ignored
        voto_valid = 1; voto_id = 1; alvo_valid = 1; alvo_id = 6; tick();
        chk("espera erro", int'(erro), 0);
        // night: kill player 2
        inicio_noite = 1; tick();
        alvo_valid = 1; alvo_id = 2; tick();
        protege_valid = 1; protege_id = 4; tick();
        fim_noite = 1; tick();
        chk("resolve fase", int'(fase), 2);
        tick();
        chk("kill2 mortes", int'(mortes), 5'b00100);
        chk("kill2 mv", int'(morte_valid), 1);
        chk("kill2 id", int'(morte_id), 2);
        chk("kill2 fase", int'(fase), 3);
        // day votes: dead, out of range, then legal
        voto_valid = 1; voto_id = 2; tick();
        chk("vote dead erro", int'(erro), 1);
        chk("vote dead fase", int'(fase), 3);
        voto_valid = 1; voto_id = 5; tick();
        chk("vote5 erro", int'(erro), 1);
        voto_valid = 1; voto_id = 0; tick();
        chk("vote0 mortes", int'(mortes), 5'b00101);
        chk("vote0 id", int'(morte_id), 0);
        chk("vote0 fase", int'(fase), 0);
        // night: dead target rejected, last target wins, protected
        inicio_noite = 1; tick();
        alvo_valid = 1; alvo_id = 0; tick();
        chk("dead alvo erro", int'(erro), 1);
        alvo_valid = 1; alvo_id = 3; tick();
        alvo_valid = 1; alvo_id = 1; tick();
        protege_valid = 1; protege_id = 1; tick();
        fim_noite = 1; tick();
        tick();
        chk("saved mv", int'(morte_valid), 0);
        chk("saved mortes", int'(mortes), 5'b00101);
        chk("saved fase", int'(fase), 3);
        // skip vote, then target captured together with fim_noite
        voto_valid = 1; voto_id = 7; tick();
        chk("skip fase", int'(fase), 0);
        chk("skip mv", int'(morte_valid), 0);
        chk("skip erro", int'(erro), 0);
        inicio_noite = 1; tick();
        alvo_valid = 1; alvo_id = 4; fim_noite = 1; tick();
        tick();
        chk("same-cycle mortes", int'(mortes), 5'b10101);
        chk("same-cycle id", int'(morte_id), 4);
        // reinicia beats a legal vote
        reinicia = 1; voto_valid = 1; voto_id = 1; tick();
        chk("reinicia fase", int'(fase), 0);
        chk("reinicia mortes", int'(mortes), 0);
        chk("reinicia id", int'(morte_id), 0);
        chk("reinicia mv", int'(morte_valid), 0);
        tick();
        @(negedge clock);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/registro_mortes.md
Name: registro_mortes

Overview:
- Sequential game-state keeper upstream of the death counter. It owns the sticky 5-bit dead-player vector `mortes` that the counter sums.
- Sequences each round: the night phase collects the wolf target and the doctor's protection, the resolve step applies the night kill, and the day phase applies the village vote.
- Flags illegal requests and emits a one-cycle event for every new death.

Parameters:
- N_JOGADORES, 5, number of players; width of `mortes`.
- ID_W, 3, player-id width; id 7 is reserved as "skip" (ID_PULA).

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- reinicia  in  1  synchronous new-game clear; highest priority after reset.
- inicio_noite  in  1  pulse; starts the night phase.
- alvo_valid  in  1  wolf target strobe.
- alvo_id  in  ID_W  wolf target id.
- protege_valid  in  1  doctor protection strobe.
- protege_id  in  ID_W  protected player id.
- fim_noite  in  1  pulse; closes the night phase.
- voto_valid  in  1  village vote result strobe.
- voto_id  in  ID_W  voted player id, or ID_PULA for no elimination.
- mortes  out  N_JOGADORES  registered dead vector; bit i=1 means player i is dead.
- morte_valid  out  1  one-cycle pulse when a new death is recorded.
- morte_id  out  ID_W  id of the player that just died; holds its last value.
- erro  out  1  one-cycle pulse on an illegal request.
- fase  out  2  current state: 00 ESPERA, 01 NOITE, 10 RESOLVE, 11 DIA.

Behaviour:
- Reset (reset_n=0, asynchronous) sets:
  - fase=ESPERA, mortes=0, morte_valid=0, morte_id=0, erro=0;
  - internal alvo_set=0, prot_set=0.
- reinicia=1 on a clock edge gives the same values as reset, synchronously, and overrides every other input that cycle.
- An id is "legal" when id<N_JOGADORES and mortes[id]=0.
- All outputs are registered. morte_valid and erro default to 0 every cycle unless set below.
- ESPERA:
  - inicio_noite -> NOITE; clears alvo_set and prot_set.
  - All other strobes are ignored; no erro.
- NOITE:
  - alvo_valid with a legal id latches alvo, sets alvo_set. The last write wins.
  - alvo_valid with an illegal id pulses erro; the latch is unchanged.
  - protege_valid follows the same rules for prot/prot_set.
  - fim_noite -> RESOLVE. A strobe arriving in the same cycle as fim_noite is still captured.
  - voto_valid is ignored.
- RESOLVE: exactly one cycle, inputs ignored, then -> DIA.
  - If alvo_set and not (prot_set and prot==alvo): set mortes[alvo], morte_valid=1, morte_id=alvo.
  - Otherwise no death.
- DIA:
  - voto_valid with a legal id: set mortes[id], pulse morte_valid, morte_id=id, -> ESPERA.
  - voto_valid with voto_id=ID_PULA: -> ESPERA, no death.
  - voto_valid with any other id (5, 6, or an already-dead player): pulse erro, stay in DIA.
  - inicio_noite is ignored.
- mortes bits only ever go 0->1, except through reset or reinicia.
- A game where everyone is dead is not blocked here; game-end detection happens downstream from the count.

Decomposition:
- Package lobinho_pkg holds:
  - N_JOGADORES, ID_W, ID_PULA;
  - the fase enum: ESPERA, NOITE, RESOLVE, DIA.
- The package is shared with the counter and game controller.
- One small combinational sub-module is natural: id_legal (inputs id and mortes; output legal). It is reused by the target, protection and vote paths.
- The FSM and registers stay in registro_mortes.

Test Plan:
- Reset mid-NOITE with alvo latched -> fase=00, mortes=00000, no morte_valid afterwards even if fim_noite arrives.
- inicio_noite; alvo 2; protege 4; fim_noite -> RESOLVE cycle sets mortes=00100, morte_valid pulse, morte_id=2, fase=11.
- Night with alvo 3 then alvo 1 (last wins), protege 1 -> no death, mortes unchanged, fase reaches DIA.
- DIA: voto 2 (already dead) -> erro pulse, fase stays 11; voto 5 -> erro; voto 0 -> mortes=00101, morte_id=0, fase=00.
- DIA: voto_id=7 -> fase=00, mortes unchanged, no pulses. Then alvo_valid+fim_noite in the same cycle with alvo 4 -> mortes bit 4 set after RESOLVE.
- reinicia asserted together with voto_valid in DIA -> all outputs at reset values, vote discarded.
